// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 2-flop input synchronizer and valid/ready byte delivery.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote over the synchronized line.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  // Handshake: a byte transfers on any clk edge where rx_valid & rx_ready are both 1;
  // rx_valid and rx_data hold steady until that edge.

  localparam logic [9:0] HALF = 10'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t     state, state_n;
  logic       sync1, sync2;
  logic       line;
  logic [9:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic       deliver, stop_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      sync2 <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (reset) hist <= 2'b11;
    else       hist <= {hist[0], sync2};
  end

  // Current sync2 votes with its two predecessors, so one-cycle glitches are outvoted.
  assign line = (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
`else
  assign line = sync2;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!line) state_n = START;
      START:   if (cnt == HALF) state_n = line ? IDLE : DATA;
      DATA:    if (cnt == LAST && idx == 3'd7) state_n = STOP;
      STOP:    if (cnt == LAST) state_n = line ? IDLE : BRK;
      BRK:     if (line) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    deliver  = (state == STOP) && (cnt == LAST) && line;
    stop_bad = (state == STOP) && (cnt == LAST) && !line;
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      sh  <= '0;
    end else begin
      case (state)
        START: begin
          cnt <= (cnt == HALF) ? 10'd0 : cnt + 10'd1;
          idx <= '0;
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            sh[idx] <= line;
            idx     <= idx + 3'd1;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        STOP: cnt <= (cnt == LAST) ? 10'd0 : cnt + 10'd1;
        default: begin
          cnt <= '0;
          idx <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= deliver && rx_valid && !rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus random bytes
// checked against a frame-level model of 8N1 reception and its timing.
module tb_uart_rx_byte;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       reset;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx_pin(rx_pin), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun_err(overrun_err), .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Monitor state, updated once per cycle #1 after the active edge
  int         valid_cycles, ferr_cnt, ovr_cnt, busy_seen, last_ovr;
  logic       prev_valid = 1'b0;
  int         rise_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         exp_t_q[$];

  task automatic clear_mon();
    valid_cycles = 0; ferr_cnt = 0; ovr_cnt = 0; busy_seen = 0; last_ovr = -1;
    rise_q.delete(); obs_q.delete(); exp_q.delete(); exp_t_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid) begin
      valid_cycles++;
      if (!prev_valid) begin
        rise_q.push_back(cyc);
        obs_q.push_back(rx_data);
      end
    end
    prev_valid = rx_valid;
    if (frame_err) ferr_cnt++;
    if (overrun_err) begin ovr_cnt++; last_ovr = cyc; end
    if (busy) busy_seen++;
  endtask

  task automatic idle(input int n);
    rx_pin = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Model: byte registered on the stop-sample edge, seen right after it
  function automatic int exp_deliver(input int t);
    return t + 2 + HALF + 1 + 9 * CPB + LAT;
  endfunction

  // Driver: one full frame; optional one-cycle inversion and reset-abort offsets
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int glitch_off, input int abort_off, output int t);
    logic [9:0] fr;
    logic       bitv;
    fr = {stop_bit, b, 1'b0};
    t = cyc + 1;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i == abort_off) begin
        reset = 1'b1;
        rx_pin = 1'b1;
        return;
      end
      bitv = fr[i / CPB];
      rx_pin = (i == glitch_off) ? ~bitv : bitv;
      tick();
    end
    rx_pin = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_pin = 1'b1; rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    total++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", frame_err, overrun_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    idle(4);
  endtask

  task automatic test_single();
    int t;
    clear_mon();
    send_frame(8'h54, 1'b1, -1, -1, t);
    idle(20);
    total++; if (rise_q.size() != 1 || rise_q[0] != exp_deliver(t)) begin bad++; $display("FAIL single_time got=%0d exp=%0d n=%0d", (rise_q.size() > 0) ? rise_q[0] - t : -1, exp_deliver(t) - t, rise_q.size()); end
    total++; if (obs_q.size() != 1 || obs_q[0] !== 8'h54) begin bad++; $display("FAIL single_data got=%h exp=54", (obs_q.size() > 0) ? obs_q[0] : 8'hxx); end
    total++; if (valid_cycles != 1) begin bad++; $display("FAIL single_valid_len got=%0d exp=1", valid_cycles); end
    total++; if (ferr_cnt != 0 || ovr_cnt != 0) begin bad++; $display("FAIL single_err got=%0d/%0d exp=0/0", ferr_cnt, ovr_cnt); end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    clear_mon();
    send_frame(8'h0D, 1'b1, -1, -1, t1);
    send_frame(8'h0A, 1'b1, -1, -1, t2);
    idle(20);
    total++; if (obs_q.size() != 2 || obs_q[0] !== 8'h0D || obs_q[1] !== 8'h0A) begin bad++; $display("FAIL b2b_data n=%0d exp=0D,0A", obs_q.size()); end
    total++; if (rise_q.size() != 2 || rise_q[1] - rise_q[0] != 160 || rise_q[1] != exp_deliver(t2)) begin bad++; $display("FAIL b2b_spacing n=%0d exp_gap=160", rise_q.size()); end
    total++; if (ferr_cnt != 0 || ovr_cnt != 0) begin bad++; $display("FAIL b2b_err got=%0d/%0d exp=0/0", ferr_cnt, ovr_cnt); end
  endtask

  task automatic test_overrun();
    int t1, t2;
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h41, 1'b1, -1, -1, t1);
    idle(5);
    send_frame(8'h42, 1'b1, -1, -1, t2);
    idle(10);
    total++; if (rx_valid !== 1'b1 || rx_data !== 8'h41) begin bad++; $display("FAIL ovr_hold got=%b/%h exp=1/41", rx_valid, rx_data); end
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL ovr_deliveries got=%0d exp=1", obs_q.size()); end
    total++; if (ovr_cnt != 1 || last_ovr != exp_deliver(t2)) begin bad++; $display("FAIL ovr_pulse got=%0d@%0d exp=1@%0d", ovr_cnt, last_ovr - t2, exp_deliver(t2) - t2); end
    rx_ready = 1'b1;
    tick();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_release got=%b exp=0", rx_valid); end
    idle(5);
  endtask

  task automatic test_frame_err();
    int t;
    clear_mon();
    send_frame(8'h55, 1'b0, -1, -1, t);
    rx_pin = 1'b0;
    for (int i = 0; i < 100 * CPB; i++) tick();
    idle(2 * CPB);
    total++; if (ferr_cnt != 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt); end
    total++; if (valid_cycles != 0) begin bad++; $display("FAIL ferr_novalid got=%0d exp=0", valid_cycles); end
    clear_mon();
    send_frame(8'h31, 1'b1, -1, -1, t);
    idle(10);
    total++; if (obs_q.size() != 1 || obs_q[0] !== 8'h31) begin bad++; $display("FAIL ferr_recover got=%h exp=31", (obs_q.size() > 0) ? obs_q[0] : 8'hxx); end
  endtask

  task automatic test_glitch();
    int         t;
    logic [7:0] exp_b;
    clear_mon();
    rx_pin = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    idle(3 * CPB);
    total++; if (busy_seen == 0 || busy !== 1'b0) begin bad++; $display("FAIL glitch4_busy seen=%0d now=%b exp=>0/0", busy_seen, busy); end
    total++; if (valid_cycles != 0 || ferr_cnt != 0) begin bad++; $display("FAIL glitch4_quiet got=%0d/%0d exp=0/0", valid_cycles, ferr_cnt); end
`ifdef UART_RX_MAJORITY_EN
    clear_mon();
    rx_pin = 1'b0;
    tick();
    idle(3 * CPB);
    total++; if (busy_seen != 0) begin bad++; $display("FAIL glitch1_busy got=%0d exp=0", busy_seen); end
    exp_b = 8'hFF;
`else
    exp_b = 8'hF7;
`endif
    // One-cycle low pulse landing exactly on the line value used by the bit-3 sample
    clear_mon();
    send_frame(8'hFF, 1'b1, 2 + HALF + 1 + 4 * CPB + LAT - 2, -1, t);
    idle(10);
    total++; if (obs_q.size() != 1 || obs_q[0] !== exp_b) begin bad++; $display("FAIL glitch_bit3 got=%h exp=%h", (obs_q.size() > 0) ? obs_q[0] : 8'hxx, exp_b); end
  endtask

  task automatic test_reset_mid();
    int t;
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'hA5, 1'b1, -1, -1, t);
    idle(5);
    send_frame(8'h3C, 1'b1, -1, 5 * CPB + 5, t);
    tick();
    total++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_out got=%b/%h exp=0/00", rx_valid, rx_data); end
    total++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun_err !== 1'b0) begin bad++; $display("FAIL rst_mid_ctl got=%b%b%b exp=000", busy, frame_err, overrun_err); end
    reset = 1'b0;
    rx_ready = 1'b1;
    idle(6 * CPB);
    clear_mon();
    send_frame(8'h7A, 1'b1, -1, -1, t);
    idle(10);
    total++; if (obs_q.size() != 1 || obs_q[0] !== 8'h7A || ferr_cnt != 0) begin bad++; $display("FAIL rst_mid_next got=%h exp=7A ferr=%0d", (obs_q.size() > 0) ? obs_q[0] : 8'hxx, ferr_cnt); end
  endtask

  task automatic test_random();
    int         t;
    logic [7:0] b;
    clear_mon();
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, -1, -1, t);
      exp_q.push_back(b);
      exp_t_q.push_back(exp_deliver(t));
      idle($urandom_range(0, 30));
    end
    idle(20);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i] || rise_q[i] != exp_t_q[i]) begin bad++; $display("FAIL rand_byte%0d got=%h@%0d exp=%h@%0d", i, obs_q[i], rise_q[i], exp_q[i], exp_t_q[i]); end
    end
    total++; if (ferr_cnt != 0 || ovr_cnt != 0) begin bad++; $display("FAIL rand_err got=%0d/%0d exp=0/0", ferr_cnt, ovr_cnt); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
